// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen: pixel-rate divider, horizontal/vertical raster counters and
// registered sync/blank decodes.  All decoded outputs are computed from the
// counters' next-state values so they line up with the counters they describe.
module vga_timing_gen #(
    parameter int DIV      = 4,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        hSync,
    output logic        vSync,
    output logic        pix_en,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    // Divider width; a divide-by-one still gets a one-bit counter.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_SYNC_E  = 10'(H_SYNC);
    localparam logic [9:0]       V_SYNC_E  = 10'(V_SYNC);
    localparam logic [9:0]       H_BRT_LO  = 10'(H_SYNC + H_BP);
    localparam logic [9:0]       H_BRT_HI  = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]       V_BRT_LO  = 10'(V_SYNC + V_BP);
    localparam logic [9:0]       V_BRT_HI  = 10'(V_SYNC + V_BP + V_ACTIVE);

    logic [DIV_W-1:0] r_div;
    logic             r_pix_en;
    logic [9:0]       r_hcount;
    logic [9:0]       r_vcount;
    logic             r_bright;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_line_start;
    logic             r_frame_start;
    logic [15:0]      r_frame_count;

    logic [DIV_W-1:0] w_div_nxt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [9:0]       w_hcount_nxt;
    logic [9:0]       w_vcount_nxt;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_bright_nxt;

    // Next-state of the divider and the raster counters.
    always_comb begin
        w_div_nxt    = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        w_h_wrap     = r_pix_en && (r_hcount == H_LAST);
        w_v_wrap     = w_h_wrap && (r_vcount == V_LAST);
        w_hcount_nxt = r_hcount;
        w_vcount_nxt = r_vcount;
        if (r_pix_en) begin
            w_hcount_nxt = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
        end
        if (w_h_wrap) begin
            w_vcount_nxt = w_v_wrap ? 10'd0 : r_vcount + 10'd1;
        end
    end

    // Sync and visible-area decodes of the next counter values.
    always_comb begin
        w_hsync_nxt  = (w_hcount_nxt >= H_SYNC_E);
        w_vsync_nxt  = (w_vcount_nxt >= V_SYNC_E);
        w_bright_nxt = (w_hcount_nxt >= H_BRT_LO) && (w_hcount_nxt < H_BRT_HI) &&
                       (w_vcount_nxt >= V_BRT_LO) && (w_vcount_nxt < V_BRT_HI);
    end

    // Divider and pixel strobe: pix_en mirrors div == DIV-1 one-for-one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= w_div_nxt;
            r_pix_en <= (w_div_nxt == DIV_LAST);
        end
    end

    // Raster counters plus their zero-skew registered decodes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_bright <= 1'b0;
        end else begin
            r_hcount <= w_hcount_nxt;
            r_vcount <= w_vcount_nxt;
            r_hsync  <= w_hsync_nxt;
            r_vsync  <= w_vsync_nxt;
            r_bright <= w_bright_nxt;
        end
    end

    // Line/frame pulses and frame counter; only counter wraps raise them, so
    // leaving reset never produces a pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
            if (w_v_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign hCount      = r_hcount;
    assign vCount      = r_vcount;
    assign bright      = r_bright;
    assign hSync       = r_hsync;
    assign vSync       = r_vsync;
    assign pix_en      = r_pix_en;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter DIV, default 4, meaning: system clocks per pixel (100 MHz clk -> 25 MHz pixel rate).
REQ-002 Parameter H_SYNC, default 96, meaning: hSync pulse width in pixels.
REQ-003 Parameter H_BP, default 48, meaning: horizontal back porch in pixels.
REQ-004 Parameter H_ACTIVE, default 640, meaning: visible pixels per line.
REQ-005 Parameter H_TOTAL, default 800, meaning: pixels per line.
REQ-006 Parameter V_SYNC, default 2, meaning: vSync pulse width in lines.
REQ-007 Parameter V_BP, default 33, meaning: vertical back porch in lines.
REQ-008 Parameter V_ACTIVE, default 480, meaning: visible lines per frame.
REQ-009 Parameter V_TOTAL, default 525, meaning: lines per frame.
REQ-010 clk  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-011 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-012 hCount  output  10  current pixel column, 0..H_TOTAL-1.
REQ-013 vCount  output  10  current line, 0..V_TOTAL-1.
REQ-014 bright  output  1  high while the (hCount, vCount) pixel is visible.
REQ-015 hSync  output  1  horizontal sync, active-low.
REQ-016 vSync  output  1  vertical sync, active-low.
REQ-017 pix_en  output  1  one-clk strobe on the clk cycle in which the counters advance.
REQ-018 line_start  output  1  one-clk pulse when hCount becomes 0.
REQ-019 frame_start  output  1  one-clk pulse when (hCount, vCount) becomes (0,0).
REQ-020 frame_count  output  16  number of completed frames since reset.

Function
REQ-021 Divider: a counter div cycles 0..DIV-1 on every clk edge; pix_en SHALL be high exactly when div == DIV-1.
REQ-022 On a clk edge with pix_en high: hCount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0.
REQ-023 On that wrap: vCount SHALL increment; at V_TOTAL-1 it SHALL wrap to 0. Otherwise vCount holds.
REQ-024 Between pix_en edges, hCount and vCount SHALL hold.
REQ-025 hSync, vSync and bright are registered. Each SHALL always equal its decode of the hCount/vCount values presented in the same cycle (decoded from next-state; zero skew to the counters).
REQ-026 hSync SHALL be 0 iff hCount < H_SYNC.
REQ-027 vSync SHALL be 0 iff vCount < V_SYNC.
REQ-028 bright SHALL be 1 iff H_SYNC+H_BP <= hCount < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vCount < V_SYNC+V_BP+V_ACTIVE. With defaults: hCount 144..783 and vCount 35..514.
REQ-029 line_start SHALL be high for exactly the one clk cycle following the edge where hCount wraps to 0.
REQ-030 frame_start SHALL be high for exactly the one clk cycle following the edge where (H_TOTAL-1, V_TOTAL-1) -> (0,0). line_start SHALL also be high in that cycle.
REQ-031 frame_count SHALL increment modulo 2^16 on the same edge that raises frame_start. 65535 SHALL wrap to 0.
REQ-032 No pulse SHALL be generated by reset release itself. The first frame_start follows the first full frame.

Reset
REQ-033 While reset_n = 0, the following SHALL be held asynchronously: div=0, hCount=0, vCount=0, bright=0, hSync=0, vSync=0, pix_en=0, line_start=0, frame_start=0, frame_count=0.
REQ-034 After reset_n rises, the first pix_en SHALL be high on the 4th clk cycle (DIV=4). hCount SHALL become 1 at that edge.
REQ-035 Reset asserted mid-frame SHALL abort immediately with no partial pulse. Operation after release SHALL be identical to power-up.

Verification
REQ-036 Release reset, run 8 clks -> pix_en high in cycles 4 and 8 only; hCount 0 -> 1 -> 2; hSync = 0, vSync = 0, bright = 0.
REQ-037 Run to hCount = 95 -> 96 -> hSync rises in the same cycle hCount shows 96. At vCount = 35, hCount 143 -> 144 -> bright rises. At hCount 783 -> 784 -> bright falls.
REQ-038 Run one full frame -> exactly 1,680,000 clks (800x525x4) between frame_starts; 525 line_starts per frame; 640x480 = 307,200 pix_en cycles with bright = 1.
REQ-039 End of frame: (799,524) + pix_en -> (0,0); frame_start, line_start and frame_count 0 -> 1 in the same cycle; vSync falls.
REQ-040 Assert reset_n = 0 at hCount = 400, vCount = 200 mid-divider -> all outputs 0 without waiting for a clk edge. Release -> REQ-036 sequence repeats.
REQ-041 Force frame_count near its limit (or run 65536 frames in a fast model) -> 65535 -> 0 on the next frame_start.
